// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared types and helpers for the multi-ported integer
//                register file and its dump engine. The debug unit also
//                imports this package to decode the dump FSM state.
//  Contents    : rf_dump_state_t  - dump engine state encoding
//                c_RF_DEFAULT_NREGS - default register count
//                rf_addr_width()  - index width for a given register count
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    // Dump engine states. The encoding is fixed so the debug unit can
    // decode a probed state value without pulling in this RTL.
    typedef enum logic [1:0] {
        RF_IDLE = 2'd0,
        RF_DUMP = 2'd1,
        RF_DONE = 2'd2
    } rf_dump_state_t;

    localparam int c_RF_DEFAULT_NREGS = 32;

    // Register index width. Never returns 0, so a degenerate register
    // count still yields a legal vector width.
    function automatic int rf_addr_width(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_dump_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_dump_fsm
//  Description : Register dump engine. On dump_req (sampled in IDLE only)
//                it walks every register index from 0 to NREGS-1, offering
//                one beat per index on a valid/ready channel, then emits a
//                single-cycle dump_done pulse and returns to IDLE.
//                Register contents come from the parent storage through a
//                dedicated internal read port (mem_rd_idx / mem_rd_data),
//                which returns the plain storage value with no bypass.
//  Ports       : clk, rst_b          - clock / async active-low reset
//                dump_req            - start request
//                dump_busy           - engine not IDLE
//                dump_valid/ready    - beat handshake
//                dump_idx/dump_data  - beat payload
//                dump_done           - pulse after the last beat
//                mem_rd_idx/data     - internal storage read port
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_dump_fsm
    import regfile_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            dump_req,
    output logic            dump_busy,
    output logic            dump_valid,
    input  logic            dump_ready,
    output logic [AW-1:0]   dump_idx,
    output logic [XLEN-1:0] dump_data,
    output logic            dump_done,
    output logic [AW-1:0]   mem_rd_idx,
    input  logic [XLEN-1:0] mem_rd_data
);

    localparam logic [AW-1:0] c_LAST_IDX = AW'(NREGS - 1);

    rf_dump_state_t r_state;
    rf_dump_state_t w_state_nxt;
    logic [AW-1:0]  r_idx;
    logic           w_fire;
    logic           w_last;

    // A beat transfers only while DUMP is actually presenting data.
    assign w_fire = (r_state == RF_DUMP) && dump_ready;
    assign w_last = (r_idx == c_LAST_IDX);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= RF_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. dump_req only matters in IDLE, and DONE always
    // falls back to IDLE, so a held request restarts after one IDLE cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RF_IDLE: begin
                if (dump_req) begin
                    w_state_nxt = RF_DUMP;
                end
            end
            RF_DUMP: begin
                if (w_fire && w_last) begin
                    w_state_nxt = RF_DONE;
                end
            end
            RF_DONE: begin
                w_state_nxt = RF_IDLE;
            end
            default: begin
                w_state_nxt = RF_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Index counter. Outside DUMP it is parked at 0, so a new dump always
    // begins with register 0 and DONE already shows index 0. It advances
    // only on an accepted beat, so payload is held while ready is low.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_idx <= '0;
        end else if (r_state != RF_DUMP) begin
            r_idx <= '0;
        end else if (w_fire) begin
            r_idx <= w_last ? '0 : (r_idx + 1'b1);
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    assign mem_rd_idx = r_idx;
    assign dump_idx   = r_idx;

    always_comb begin
        dump_valid = 1'b0;
        dump_done  = 1'b0;
        dump_busy  = 1'b0;
        dump_data  = '0;
        case (r_state)
            RF_DUMP: begin
                dump_valid = 1'b1;
                dump_busy  = 1'b1;
                // Storage is read combinationally, so a beat reflects the
                // register as it stood at the start of this cycle.
                dump_data  = mem_rd_data;
            end
            RF_DONE: begin
                dump_done  = 1'b1;
                dump_busy  = 1'b1;
            end
            default: begin
                dump_valid = 1'b0;
            end
        endcase
    end

endmodule : regfile_dump_fsm
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Parametrised multi-ported integer register file with NRD
//                asynchronous read ports, NWR synchronous write ports,
//                optional same-cycle write->read bypass, optional hardwired
//                zero register, and a streaming dump engine.
//  Ports       : clk, rst_b             - clock / async active-low reset
//                rd_num   [NRD*AW]      - read index per port
//                rd_data  [NRD*XLEN]    - read data per port
//                wr_en    [NWR]         - write enable per port
//                wr_num   [NWR*AW]      - write index per port
//                wr_data  [NWR*XLEN]    - write data per port
//                dump_req/busy/valid/ready/idx/data/done - dump channel
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = c_RF_DEFAULT_NREGS,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = rf_addr_width(NREGS)
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic [NRD*AW-1:0]   rd_num,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_num,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                dump_req,
    output logic                dump_busy,
    output logic                dump_valid,
    input  logic                dump_ready,
    output logic [AW-1:0]       dump_idx,
    output logic [XLEN-1:0]     dump_data,
    output logic                dump_done
);

    logic [XLEN-1:0] r_mem [NREGS];

    logic [AW-1:0]   w_dump_rd_idx;
    logic [XLEN-1:0] w_dump_rd_data;

    // ------------------------------------------------------------------
    // Storage write. Ports are visited in ascending order and the last
    // non-blocking assignment to an element wins, so on an index clash the
    // highest-numbered enabled port is the one stored. With ZERO_REG the
    // register 0 is never written and therefore stays at its reset value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_en[p] &&
                    !((ZERO_REG != 0) && (wr_num[p*AW +: AW] == '0))) begin
                    r_mem[wr_num[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports. Bypass uses the same ascending-port priority as storage,
    // so a read during a conflicting write sees the value that will land.
    // The zero-register override is applied last so it also beats bypass.
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < NRD; g++) begin : g_rd
            logic [AW-1:0]   w_idx;
            logic [XLEN-1:0] w_val;

            assign w_idx = rd_num[g*AW +: AW];

            always_comb begin
                w_val = r_mem[w_idx];
                if (BYPASS != 0) begin
                    for (int p = 0; p < NWR; p++) begin
                        if (wr_en[p] && (wr_num[p*AW +: AW] == w_idx)) begin
                            w_val = wr_data[p*XLEN +: XLEN];
                        end
                    end
                end
                if ((ZERO_REG != 0) && (w_idx == '0)) begin
                    w_val = '0;
                end
            end

            assign rd_data[g*XLEN +: XLEN] = w_val;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Dump engine. Its read port sees raw storage only: the dump must
    // report committed register state, not in-flight write data.
    // ------------------------------------------------------------------
    assign w_dump_rd_data = r_mem[w_dump_rd_idx];

    regfile_dump_fsm #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_dump_fsm (
        .clk         (clk),
        .rst_b       (rst_b),
        .dump_req    (dump_req),
        .dump_busy   (dump_busy),
        .dump_valid  (dump_valid),
        .dump_ready  (dump_ready),
        .dump_idx    (dump_idx),
        .dump_data   (dump_data),
        .dump_done   (dump_done),
        .mem_rd_idx  (w_dump_rd_idx),
        .mem_rd_data (w_dump_rd_data)
    );

endmodule : regfile_mp
`default_nettype wire
